gc_gate_scheduler: RTL and testbench

Sequencer that streams gate descriptors through the combinational `GC_engine` garbling datapath. It fetches input wire labels from the wire-label RAM and presents them with `cid`/`gid` to the engine. It then writes the output label back to the RAM and emits the garbled table (`t0`, `t1`) for non-free gates over a valid/ready stream. Free-XOR gates are resolved locally (`in0 ^ in1`) without engine use or table emission.

---
 rtl/gc_gate_scheduler.sv | 127 ++++++++++++
 tb/tb_gc_gate_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_gate_scheduler.sv
// gc_gate_scheduler: streams gate descriptors through the garbling engine, writes labels back, emits tables
module gc_gate_scheduler #(
  parameter int S = 20,
  parameter int K = 128,
  parameter int W = 10,
  parameter int ENG_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [S-1:0] cid_in,
  input  logic [S-1:0] n_gates,
  input  logic         gate_valid,
  output logic         gate_ready,
  input  logic         gate_xor,
  input  logic [W-1:0] gate_a,
  input  logic [W-1:0] gate_b,
  input  logic [W-1:0] gate_o,
  output logic [W-1:0] ram_raddr0,
  output logic [W-1:0] ram_raddr1,
  input  logic [K-1:0] ram_rdata0,
  input  logic [K-1:0] ram_rdata1,
  output logic         ram_we,
  output logic [W-1:0] ram_waddr,
  output logic [K-1:0] ram_wdata,
  output logic [S-1:0] eng_cid,
  output logic [S-1:0] eng_gid,
  output logic [K-1:0] eng_in0,
  output logic [K-1:0] eng_in1,
  input  logic [K-1:0] eng_out_label,
  input  logic [K-1:0] eng_t0,
  input  logic [K-1:0] eng_t1,
  output logic         tab_valid,
  input  logic         tab_ready,
  output logic [K-1:0] tab_t0,
  output logic [K-1:0] tab_t1,
  output logic [S-1:0] tab_gid,
  output logic         busy,
  output logic         done
);
  localparam int LW = ENG_LAT > 1 ? $clog2(ENG_LAT) : 1;
  typedef enum logic [2:0] {IDLE, ACCEPT, LOAD, EVAL, EMIT, WB, FIN} state_t;
  state_t state;
  logic [S-1:0] cid, n, gid, cnt;
  logic [W-1:0] o;
  logic x;
  logic [K-1:0] wr;
  logic [LW-1:0] lat;
  logic [S-1:0] cnt_nx;
  assign cnt_nx = cnt + S'(1);
  assign gate_ready = state == ACCEPT;
  assign tab_valid = state == EMIT;
  assign ram_we = (state == EMIT && tab_ready) || state == WB;
  assign ram_waddr = o;
  assign ram_wdata = wr;
  assign eng_cid = cid;
  assign eng_gid = gid;
  assign busy = state != IDLE && state != FIN;
  assign done = state == FIN;
  // wr holds whichever label the next write-back commits: engine output or local XOR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cid <= '0;
      n <= '0;
      gid <= '0;
      cnt <= '0;
      o <= '0;
      x <= 1'b0;
      wr <= '0;
      lat <= '0;
      ram_raddr0 <= '0;
      ram_raddr1 <= '0;
      eng_in0 <= '0;
      eng_in1 <= '0;
      tab_t0 <= '0;
      tab_t1 <= '0;
      tab_gid <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cid <= cid_in;
          n <= n_gates;
          gid <= '0;
          cnt <= '0;
          state <= n_gates == '0 ? FIN : ACCEPT;
        end
        ACCEPT: if (gate_valid) begin
          ram_raddr0 <= gate_a;
          ram_raddr1 <= gate_b;
          o <= gate_o;
          x <= gate_xor;
          state <= LOAD;
        end
        LOAD: begin
          lat <= '0;
          if (x) begin
            wr <= ram_rdata0 ^ ram_rdata1;
            state <= WB;
          end else begin
            eng_in0 <= ram_rdata0;
            eng_in1 <= ram_rdata1;
            state <= EVAL;
          end
        end
        EVAL: if (lat == LW'(ENG_LAT - 1)) begin
          wr <= eng_out_label;
          tab_t0 <= eng_t0;
          tab_t1 <= eng_t1;
          tab_gid <= gid;
          state <= EMIT;
        end else lat <= lat + LW'(1);
        EMIT: if (tab_ready) begin
          gid <= gid + S'(1);
          cnt <= cnt_nx;
          state <= cnt_nx == n ? FIN : ACCEPT;
        end
        WB: begin
          cnt <= cnt_nx;
          state <= cnt_nx == n ? FIN : ACCEPT;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gc_gate_scheduler.sv
// tb_gc_gate_scheduler: random gate streams checked cycle by cycle against a transaction-level model
module tb_gc_gate_scheduler;
  localparam int S = 20, K = 128, W = 10, L = 3;
  logic clk = 0, rst_n = 0, start = 0, gate_valid = 0, gate_xor = 0, tab_ready = 1;
  logic [S-1:0] cid_in = '0, n_gates = '0;
  logic [W-1:0] gate_a = '0, gate_b = '0, gate_o = '0;
  logic gate_ready, ram_we, tab_valid, busy, done;
  logic [W-1:0] ram_raddr0, ram_raddr1, ram_waddr;
  logic [K-1:0] ram_rdata0, ram_rdata1, ram_wdata, eng_in0, eng_in1;
  logic [K-1:0] eng_out_label, eng_t0, eng_t1, tab_t0, tab_t1;
  logic [S-1:0] eng_cid, eng_gid, tab_gid;
  logic [K-1:0] mem [0:1023];
  logic [K-1:0] gm [0:1023];
  localparam logic [K-1:0] LA = 128'h68B695F9E1BFC0A9646FBB88694A66F7;
  localparam logic [K-1:0] LB = 128'hF965EA419F90407ABA09D714C18F5F5C;
  localparam logic [K-1:0] LX = 128'h91D37FB87E2F80D3DE666C9CA8C539AB;

  gc_gate_scheduler #(.S(S), .K(K), .W(W), .ENG_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cid_in(cid_in), .n_gates(n_gates),
    .gate_valid(gate_valid), .gate_ready(gate_ready), .gate_xor(gate_xor),
    .gate_a(gate_a), .gate_b(gate_b), .gate_o(gate_o),
    .ram_raddr0(ram_raddr0), .ram_raddr1(ram_raddr1), .ram_rdata0(ram_rdata0), .ram_rdata1(ram_rdata1),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .eng_cid(eng_cid), .eng_gid(eng_gid), .eng_in0(eng_in0), .eng_in1(eng_in1),
    .eng_out_label(eng_out_label), .eng_t0(eng_t0), .eng_t1(eng_t1),
    .tab_valid(tab_valid), .tab_ready(tab_ready), .tab_t0(tab_t0), .tab_t1(tab_t1),
    .tab_gid(tab_gid), .busy(busy), .done(done));

  // stand-in engine: any mixing of cid/gid/labels that makes each field observable
  function automatic logic [K-1:0] f_out(logic [S-1:0] c, logic [S-1:0] g, logic [K-1:0] a, logic [K-1:0] b);
    return a ^ {b[K-2:0], b[K-1]} ^ {c, {(K-2*S){1'b0}}, g};
  endfunction
  function automatic logic [K-1:0] f_t0(logic [S-1:0] c, logic [S-1:0] g, logic [K-1:0] a, logic [K-1:0] b);
    return (a + b) ^ {g, {(K-2*S){1'b0}}, c};
  endfunction
  function automatic logic [K-1:0] f_t1(logic [S-1:0] c, logic [S-1:0] g, logic [K-1:0] a, logic [K-1:0] b);
    return (a - b) ^ {{(K-S){1'b0}}, g ^ c};
  endfunction
  assign eng_out_label = f_out(eng_cid, eng_gid, eng_in0, eng_in1);
  assign eng_t0 = f_t0(eng_cid, eng_gid, eng_in0, eng_in1);
  assign eng_t1 = f_t1(eng_cid, eng_gid, eng_in0, eng_in1);
  assign ram_rdata0 = mem[ram_raddr0];
  assign ram_rdata1 = mem[ram_raddr1];

  logic any_out;
  assign any_out = |{gate_ready, tab_valid, ram_we, busy, done, ram_raddr0, ram_raddr1, ram_waddr, ram_wdata,
                     eng_cid, eng_gid, eng_in0, eng_in1, tab_t0, tab_t1, tab_gid};

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic x;
    logic [W-1:0] o;
    logic [K-1:0] res, t0, t1;
    logic [S-1:0] gid;
    int due;
  } exp_t;
  exp_t q[$];
  logic [S-1:0] tab_gids[$];
  logic midle = 1;
  logic [S-1:0] mcid = '0, mn = '0, mgid = '0;
  int acc = 0, rdy_due = 0, fin_due = -1;
  int wr_cnt = 0, done_cnt = 0, done_cyc = -1, tv_cycles = 0, gr_cycles = 0;

  // model: one gate in flight, each gate's effects fully determined at acceptance
  always @(negedge clk) begin
    exp_t h, e;
    logic hv, tv_e, we_e, gr_e;
    if (!rst_n) begin
      chk("reset_zero", K'(any_out), '0);
      q.delete();
      midle = 1;
      fin_due = -1;
      mgid = '0;
    end else begin
      hv = q.size() > 0;
      if (hv) h = q[0];
      tv_e = hv && !h.x && cyc >= h.due;
      we_e = hv && (h.x ? cyc == h.due : tv_e && tab_ready);
      gr_e = !midle && !hv && acc < int'(mn) && cyc >= rdy_due && cyc != fin_due;
      chk("gate_ready", K'(gate_ready), K'(gr_e));
      chk("tab_valid", K'(tab_valid), K'(tv_e));
      chk("ram_we", K'(ram_we), K'(we_e));
      chk("done", K'(done), K'(cyc == fin_due));
      chk("busy", K'(busy), K'(!midle && cyc != fin_due));
      if (tab_valid) tv_cycles++;
      if (gate_ready) gr_cycles++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (ram_we) begin mem[ram_waddr] = ram_wdata; wr_cnt++; end
      if (tab_valid && tv_e) begin
        chk("tab_t0", tab_t0, h.t0);
        chk("tab_t1", tab_t1, h.t1);
        chk("tab_gid", K'(tab_gid), K'(h.gid));
      end
      if (ram_we && we_e) begin
        chk("ram_waddr", K'(ram_waddr), K'(h.o));
        chk("ram_wdata", ram_wdata, h.res);
        gm[h.o] = h.res;
        if (!h.x) begin mgid = mgid + S'(1); tab_gids.push_back(tab_gid); end
        void'(q.pop_front());
        rdy_due = cyc + 1;
        if (acc == int'(mn)) fin_due = cyc + 1;
      end
      if (gate_valid && gate_ready && gr_e) begin
        e.x = gate_xor;
        e.o = gate_o;
        e.res = gate_xor ? gm[gate_a] ^ gm[gate_b] : f_out(mcid, mgid, gm[gate_a], gm[gate_b]);
        e.t0 = f_t0(mcid, mgid, gm[gate_a], gm[gate_b]);
        e.t1 = f_t1(mcid, mgid, gm[gate_a], gm[gate_b]);
        e.gid = mgid;
        e.due = cyc + 2 + (gate_xor ? 0 : L);
        q.push_back(e);
        acc++;
      end
      if (start && midle) begin
        mcid = cid_in; mn = n_gates; mgid = '0; acc = 0; midle = 0; rdy_due = cyc + 1;
        if (n_gates == '0) fin_due = cyc + 1;
      end else if (cyc == fin_due) midle = 1;
    end
  end

  int tab_mode = 0, stall = 0;
  initial forever begin
    @(posedge clk); #1;
    stall = tab_valid ? stall + 1 : 0;
    tab_ready = tab_mode == 0 ? 1'b1 : tab_mode == 1 ? 1'($urandom_range(0, 1)) : stall > 10;
  end

  int st_cyc;
  task automatic start_run(input int n, input logic [S-1:0] c);
    start = 1; n_gates = S'(n); cid_in = c; st_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_gate(input logic x, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] o);
    int k;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    gate_valid = 1; gate_xor = x; gate_a = a; gate_b = b; gate_o = o;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (gate_ready) break;
    end
    if (k == 400) chk("gate_timeout", 1, 0);
    @(posedge clk); #1;
    gate_valid = 0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", K'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic rnd_gate();
    send_gate(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
  endtask

  initial begin
    int w0, d0, t0, g0;
    logic [K-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      mem[i] = v; gm[i] = v;
    end
    mem[1] = LA; gm[1] = LA; mem[2] = LB; gm[2] = LB;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    // free-XOR gate against the known label vector
    w0 = wr_cnt; t0 = tv_cycles;
    start_run(1, '0);
    send_gate(1, 1, 2, 4);
    wait_done();
    chk("xor_vector", mem[4], LX);
    chk("xor_writes", K'(wr_cnt - w0), 1);
    chk("xor_no_table", K'(tv_cycles - t0), 0);
    // single AND gate, cid 0, gid 0
    tab_gids.delete();
    start_run(1, '0);
    send_gate(0, 1, 2, 3);
    wait_done();
    chk("and_label", mem[3], f_out('0, '0, LA, LB));
    chk("and_gid", K'(tab_gids[0]), 0);
    // AND, XOR, AND: gids 0 then 1, three writes, one done
    tab_gids.delete(); w0 = wr_cnt; d0 = done_cnt;
    start_run(3, 20'h5A5A5);
    send_gate(0, 1, 2, 5);
    send_gate(1, 5, 2, 6);
    send_gate(0, 6, 5, 7);
    wait_done();
    chk("mixed_tabs", K'(tab_gids.size()), 2);
    chk("mixed_gid0", K'(tab_gids[0]), 0);
    chk("mixed_gid1", K'(tab_gids[1]), 1);
    chk("mixed_writes", K'(wr_cnt - w0), 3);
    chk("mixed_done", K'(done_cnt - d0), 1);
    // tab_ready stalled for 10 EMIT cycles
    tab_mode = 2; t0 = tv_cycles;
    start_run(1, 20'h00123);
    send_gate(0, 3, 4, 8);
    wait_done();
    chk("stall_valid_cycles", K'(tv_cycles - t0), 11);
    tab_mode = 0;
    // zero-gate run: done the cycle after start, no gate_ready
    g0 = gr_cycles; d0 = done_cnt;
    start_run(0, '0);
    wait_done();
    chk("zero_done_cycle", K'(done_cyc), K'(st_cyc + 1));
    chk("zero_no_ready", K'(gr_cycles - g0), 0);
    chk("zero_done_cnt", K'(done_cnt - d0), 1);
    // start while busy is ignored
    w0 = wr_cnt; d0 = done_cnt;
    start_run(2, 20'h00777);
    start_run(0, 20'h00999);
    rnd_gate();
    rnd_gate();
    wait_done();
    chk("busy_start_writes", K'(wr_cnt - w0), 2);
    chk("busy_start_done", K'(done_cnt - d0), 1);
    // asynchronous reset while in EVAL
    w0 = wr_cnt; v = mem[9];
    start_run(1, 20'h0ABCD);
    send_gate(0, 1, 2, 9);
    @(posedge clk); #2;
    rst_n = 0;
    #1 chk("async_reset_zero", K'(any_out), '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("reset_no_write", K'(wr_cnt - w0), 0);
    chk("reset_label_kept", mem[9], v);
    tab_gids.delete();
    start_run(1, 20'h0ABCD);
    send_gate(0, 1, 2, 9);
    wait_done();
    chk("post_reset_gid", K'(tab_gids[0]), 0);
    // randomized runs with random back-pressure
    tab_mode = 1;
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 6);
      start_run(n, S'($urandom));
      for (int i = 0; i < n; i++) rnd_gate();
      wait_done();
    end
    tab_mode = 0;
    for (int i = 0; i < 16; i++) chk("final_ram", mem[i], gm[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
